// File: rtl/cpu_bus_pkg.sv
// Shared constants for the 16-bit CPU bus, and the responder state encoding.
// The control unit imports the width constants from here as well.
package cpu_bus_pkg;

  localparam int BUS_DATA_W = 16;
  localparam int BUS_ADDR_W = 10;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word array.
//   clk, rst : clock; active-low async reset (read register only, array not reset)
//   en       : perform an access this edge
//   we       : 1 = write wdata to addr, 0 = read addr
//   addr     : word index
//   wdata    : write data
//   rdata    : registered data of the last access (written data on writes)
module mem_array_sp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Write-through on writes so a response always echoes what was stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (en) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU bus: accepts one request, holds it for
// WAIT_CYCLES wait states, performs one array access and pulses resp_valid.
//   clk, rst   : clock; active-low async reset
//   req_*      : request from AR/DR (valid, we, addr, wdata)
//   req_ready  : high in IDLE, request accepted when req_valid also high
//   resp_valid : one-cycle completion pulse
//   resp_rdata : read data or echoed write data (0 on out-of-range)
//   resp_err   : last access was out of range
//   busy       : a request is in flight
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, counting down wait states
// RESP  | access done, resp_valid high for this cycle
module mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W      = BUS_DATA_W,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_responder: WAIT_CYCLES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("mem_responder: DEPTH must be 1..2**ADDR_W");
    end
  endgenerate

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q;
  logic                    we_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    err_q;
  logic                    capture, access;

  logic [ADDR_W-1:0]       acc_addr;
  logic                    acc_we;
  logic [DATA_W-1:0]       acc_wdata;
  logic                    acc_in_range;
  logic [DATA_W-1:0]       mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (access) err_q <= !acc_in_range;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so it
  // must use the live request rather than the holding registers.
  always_comb begin
    acc_addr  = capture ? req_addr  : addr_q;
    acc_we    = capture ? req_we    : we_q;
    acc_wdata = capture ? req_wdata : wdata_q;
  end

  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_L);

  mem_array_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (access && acc_in_range),
    .we    (acc_we),
    .addr  (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // The array read register is left untouched on out-of-range accesses;
  // the error flag masks it to zero instead.
  assign resp_rdata = err_q ? '0 : mem_rdata;
  assign resp_err   = err_q;
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);

endmodule
